oled_init: RTL

Power-up sequencer for the SSD1306-based OLED, sitting directly upstream of the operational screen FSM. After `en` it:
- brings up VDD, pulses RES and turns on VBAT with the required delays;
- streams the configuration command bytes through the shared SPI controller.

It raises `fin`, which the top level uses to mux the SPI controller over to the operational FSM and to start it.

---
 rtl/oled_pkg.sv | 56 +++++
 rtl/init_delay.sv | 43 ++++
 rtl/oled_init.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared OLED types, command bytes and init step encoding
package oled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SPI1,
    ST_SPI2,
    ST_DLY,
    ST_DONE
  } state_t;

  typedef enum logic {
    STEP_ACT,
    STEP_CMD
  } step_kind_t;

  // Which power/reset pin an ACT step writes
  typedef enum logic [1:0] {
    PIN_VDD_ON,
    PIN_RES_LO,
    PIN_RES_HI,
    PIN_VBAT_ON
  } pin_act_t;

  typedef struct packed {
    step_kind_t kind;
    pin_act_t   pin;
    logic       dly_long;  // 1: VBAT settle delay, 0: short power delay
    logic [7:0] data;
  } step_t;

  localparam int N_INIT_STEPS = 16;

  localparam logic [7:0] CMD_DISP_OFF      = 8'hAE;
  localparam logic [7:0] CMD_CHG_PUMP      = 8'h8D;
  localparam logic [7:0] CMD_CHG_PUMP_ON   = 8'h14;
  localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
  localparam logic [7:0] CMD_PRECHARGE_VAL = 8'hF1;
  localparam logic [7:0] CMD_CONTRAST      = 8'h81;
  localparam logic [7:0] CMD_CONTRAST_VAL  = 8'h0F;
  localparam logic [7:0] CMD_SEG_REMAP     = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN_DEC  = 8'hC8;
  localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
  localparam logic [7:0] CMD_COM_PINS_VAL  = 8'h20;
  localparam logic [7:0] CMD_DISP_ON       = 8'hAF;

  function automatic step_t cmd_step(input logic [7:0] b);
    cmd_step = '{kind: STEP_CMD, pin: PIN_VDD_ON, dly_long: 1'b0, data: b};
  endfunction

  function automatic step_t act_step(input pin_act_t p, input logic long_dly);
    act_step = '{kind: STEP_ACT, pin: p, dly_long: long_dly, data: 8'h00};
  endfunction

endpackage

// File: rtl/init_delay.sv
// rtl/init_delay.sv - millisecond countdown used between power-up actions
module init_delay import oled_pkg::*; #(
  parameter int CLKS_PER_MS = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [6:0] ms,
  output logic       fin
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] pre;
  logic [6:0]    ms_cnt;
  logic          tick;

  assign tick = (pre == PRE_LAST);
  // fin marks the last cycle of the delay so the caller leaves on that edge,
  // giving exactly ms*CLKS_PER_MS enabled cycles
  assign fin  = en && ((ms_cnt == 7'd0) || ((ms_cnt == 7'd1) && tick));

  // Prescaler divides clk down to ms ticks; ms_cnt counts them down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre    <= '0;
      ms_cnt <= '0;
    end else if (load) begin
      pre    <= '0;
      ms_cnt <= ms;
    end else if (en && (ms_cnt != 7'd0)) begin
      if (tick) begin
        pre    <= '0;
        ms_cnt <= ms_cnt - 7'd1;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/oled_init.sv
// rtl/oled_init.sv - SSD1306 power-up and configuration sequencer
module oled_init import oled_pkg::*; #(
  parameter int CLKS_PER_MS = 100000,
  parameter int DLY_PWR_MS  = 1,
  parameter int DLY_VBAT_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       spi_fin,
  output logic       spi_en,
  output logic [7:0] spi_data,
  output logic       dc,
  output logic       vdd_n,
  output logic       vbat_n,
  output logic       res_n,
  output logic       fin
);

  state_t     state, state_d;
  logic [4:0] step, step_d;
  logic       spi_en_d, vdd_n_d, vbat_n_d, res_n_d;
  logic [7:0] spi_data_d;
  step_t      cur;
  logic       dly_load, dly_en, dly_fin;
  logic [6:0] dly_ms;

  assign dc = 1'b0;

  // Step table: power actions interleaved with configuration bytes
  always_comb begin
    cur = cmd_step(8'h00);
    case (step)
      5'd0:    cur = act_step(PIN_VDD_ON, 1'b0);
      5'd1:    cur = cmd_step(CMD_DISP_OFF);
      5'd2:    cur = act_step(PIN_RES_LO, 1'b0);
      5'd3:    cur = act_step(PIN_RES_HI, 1'b0);
      5'd4:    cur = cmd_step(CMD_CHG_PUMP);
      5'd5:    cur = cmd_step(CMD_CHG_PUMP_ON);
      5'd6:    cur = cmd_step(CMD_PRECHARGE);
      5'd7:    cur = cmd_step(CMD_PRECHARGE_VAL);
      5'd8:    cur = act_step(PIN_VBAT_ON, 1'b1);
      5'd9:    cur = cmd_step(CMD_CONTRAST);
      5'd10:   cur = cmd_step(CMD_CONTRAST_VAL);
      5'd11:   cur = cmd_step(CMD_SEG_REMAP);
      5'd12:   cur = cmd_step(CMD_COM_SCAN_DEC);
      5'd13:   cur = cmd_step(CMD_COM_PINS);
      5'd14:   cur = cmd_step(CMD_COM_PINS_VAL);
      5'd15:   cur = cmd_step(CMD_DISP_ON);
      default: cur = cmd_step(8'h00);
    endcase
  end

  assign dly_ms = cur.dly_long ? 7'(DLY_VBAT_MS) : 7'(DLY_PWR_MS);

  init_delay #(.CLKS_PER_MS(CLKS_PER_MS)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .load (dly_load),
    .en   (dly_en),
    .ms   (dly_ms),
    .fin  (dly_fin)
  );

  // Next-state and next-output decode; pins hold unless an ACT step writes one
  always_comb begin
    state_d    = state;
    step_d     = step;
    spi_en_d   = spi_en;
    spi_data_d = spi_data;
    vdd_n_d    = vdd_n;
    vbat_n_d   = vbat_n;
    res_n_d    = res_n;
    dly_load   = 1'b0;
    dly_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        step_d = 5'd0;
        if (en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (step == 5'(N_INIT_STEPS)) begin
          state_d = ST_DONE;
        end else if (cur.kind == STEP_CMD) begin
          spi_data_d = cur.data;
          state_d    = ST_SPI1;
        end else begin
          case (cur.pin)
            PIN_VDD_ON:  vdd_n_d  = 1'b0;
            PIN_RES_LO:  res_n_d  = 1'b0;
            PIN_RES_HI:  res_n_d  = 1'b1;
            PIN_VBAT_ON: vbat_n_d = 1'b0;
            default:     ;
          endcase
          dly_load = 1'b1;
          state_d  = ST_DLY;
        end
      end
      ST_SPI1: begin
        spi_en_d = 1'b1;
        state_d  = ST_SPI2;
      end
      ST_SPI2: begin
        if (spi_fin) begin
          spi_en_d = 1'b0;
          step_d   = step + 5'd1;
          state_d  = ST_FETCH;
        end
      end
      ST_DLY: begin
        dly_en = 1'b1;
        if (dly_fin) begin
          step_d  = step + 5'd1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (!en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, step counter and all outputs registered; reset drops the rails
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      step     <= 5'd0;
      spi_en   <= 1'b0;
      spi_data <= 8'h00;
      vdd_n    <= 1'b1;
      vbat_n   <= 1'b1;
      res_n    <= 1'b1;
      fin      <= 1'b0;
    end else begin
      state    <= state_d;
      step     <= step_d;
      spi_en   <= spi_en_d;
      spi_data <= spi_data_d;
      vdd_n    <= vdd_n_d;
      vbat_n   <= vbat_n_d;
      res_n    <= res_n_d;
      fin      <= (state_d == ST_DONE);
    end
  end

endmodule
